// File: rtl/ptp_bridge_pkg.sv
// rtl/ptp_bridge_pkg.sv - shared segment-info type, arbiter state enum and round-robin pick helper
package ptp_bridge_pkg;

  localparam int IGR_PORT_W = 4;
  localparam int MAX_PORTS  = 16;

  typedef struct packed {
    logic [IGR_PORT_W-1:0] igr_port;
    logic [7:0]            seg_len;
    logic                  sop;
    logic                  eop;
  } SEGMENT_INFO_S;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } ARB_STATE_E;

  // First set bit of req at or after ptr, wrapping at num; returns ptr when req is empty.
  function automatic logic [3:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input logic [3:0]           ptr,
                                         input int                   num);
    logic [3:0] pick;
    logic       found;
    logic [4:0] idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= 5'(num)) idx = idx - 5'(num);
      if (!found && (i < num) && req[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/egr_wadj_arb_skid.sv
// rtl/egr_wadj_arb_skid.sv - 2-entry registered skid buffer with a flop-driven ready
module egr_wadj_arb_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_tvalid,
  input  logic [WIDTH-1:0] in_tdata,
  output logic             in_tready,
  output logic             out_tvalid,
  output logic [WIDTH-1:0] out_tdata,
  input  logic             out_tready
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, tail_q;
  logic             ready_q;
  logic             push, pop;

  assign push       = in_tvalid & ready_q;
  assign pop        = (count_q != 2'd0) & out_tready;
  assign in_tready  = ready_q;
  assign out_tvalid = (count_q != 2'd0);
  assign out_tdata  = head_q;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Head is always the beat on the output; ready looks ahead so it never depends on out_tready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_tdata;
          else                 tail_q <= in_tdata;
        end
        2'b01: head_q <= tail_q;
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= in_tdata;
          end else begin
            head_q <= tail_q;
            tail_q <= in_tdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/egr_wadj_port_arb.sv
// rtl/egr_wadj_port_arb.sv - packet-locked round-robin arbiter feeding the segment splitter (option: EGR_WADJ_ARB_PRIO_EN)
module egr_wadj_port_arb
  import ptp_bridge_pkg::*;
#(
  parameter  int NUM_PORTS          = 4,
  parameter  int TDATA_WIDTH        = 512,
  parameter  int USERMETADATA_WIDTH = 1,
  localparam int PORT_WD            = $clog2(NUM_PORTS)
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_PORTS-1:0]                          igr_tvalid,
  input  logic [NUM_PORTS-1:0][TDATA_WIDTH-1:0]         igr_tdata,
  input  logic [NUM_PORTS-1:0][TDATA_WIDTH/8-1:0]       igr_tkeep,
  input  logic [NUM_PORTS-1:0]                          igr_tlast,
  input  logic [NUM_PORTS-1:0][USERMETADATA_WIDTH-1:0]  igr_tuser_usermetadata,
  input  SEGMENT_INFO_S [NUM_PORTS-1:0]                 igr_tuser_segment_info,
  output logic [NUM_PORTS-1:0]                          igr_tready,
  output logic                                          egr_tvalid,
  output logic [TDATA_WIDTH-1:0]                        egr_tdata,
  output logic [TDATA_WIDTH/8-1:0]                      egr_tkeep,
  output logic                                          egr_tlast,
  output logic [USERMETADATA_WIDTH-1:0]                 egr_tuser_usermetadata,
  output SEGMENT_INFO_S                                 egr_tuser_segment_info,
  input  logic                                          egr_tready,
  output logic [PORT_WD-1:0]                            egr_grant_port,
  output logic                                          arb_busy
);

  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int SEG_W  = $bits(SEGMENT_INFO_S);
  localparam int PAY_W  = TDATA_WIDTH + KEEP_W + USERMETADATA_WIDTH + 1 + SEG_W;

  ARB_STATE_E         state_q, state_d;
  logic [PORT_WD-1:0] grant_q, grant_d;
  logic [PORT_WD-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_WD-1:0] pick;
  logic [PORT_WD-1:0] ptr_inc;
  logic               skid_ready;
  logic               skid_valid;
  logic               accept;
  logic               pkt_end;
  SEGMENT_INFO_S      seg_in;
  logic [PAY_W-1:0]   skid_in;
  logic [PAY_W-1:0]   skid_out;
  logic [MAX_PORTS-1:0] req_ext;

  assign req_ext = MAX_PORTS'(igr_tvalid);
  assign ptr_inc = (grant_q == PORT_WD'(NUM_PORTS - 1)) ? '0 : grant_q + PORT_WD'(1);
  assign accept  = (state_q == PKT) & skid_ready & igr_tvalid[grant_q];
  assign pkt_end = accept & igr_tlast[grant_q];

`ifdef EGR_WADJ_ARB_PRIO_EN
  // Port 0 pre-empts the rotation; the rest rotate with port 0 masked out.
  always_comb begin
    pick = '0;
    if (!igr_tvalid[0])
      pick = PORT_WD'(rr_pick(req_ext & ~MAX_PORTS'(1), 4'(rr_ptr_q), NUM_PORTS));
  end
`else
  // Plain rotation over all ports starting at rr_ptr.
  always_comb begin
    pick = PORT_WD'(rr_pick(req_ext, 4'(rr_ptr_q), NUM_PORTS));
  end
`endif

  // Arbiter state, grant and rotation pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state: grant in IDLE, hold until the granted port's tlast is taken.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    igr_tready = '0;
    case (state_q)
      IDLE: begin
        if (|igr_tvalid) begin
          state_d = PKT;
          grant_d = pick;
        end
      end
      PKT: begin
        igr_tready[grant_q] = skid_ready;
        if (pkt_end) begin
          state_d = IDLE;
`ifdef EGR_WADJ_ARB_PRIO_EN
          if (grant_q != '0) rr_ptr_d = ptr_inc;
`else
          rr_ptr_d = ptr_inc;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Selected port's beat with its segment info stamped with the granted index.
  always_comb begin
    seg_in          = igr_tuser_segment_info[grant_q];
    seg_in.igr_port = IGR_PORT_W'(grant_q);
    skid_in         = {igr_tdata[grant_q], igr_tkeep[grant_q], igr_tuser_usermetadata[grant_q],
                       igr_tlast[grant_q], seg_in};
  end

  egr_wadj_arb_skid #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tvalid  (accept),
    .in_tdata   (skid_in),
    .in_tready  (skid_ready),
    .out_tvalid (skid_valid),
    .out_tdata  (skid_out),
    .out_tready (egr_tready)
  );

  assign egr_tvalid = skid_valid;
  assign {egr_tdata, egr_tkeep, egr_tuser_usermetadata, egr_tlast, egr_tuser_segment_info} = skid_out;
  assign egr_grant_port = grant_q;
  assign arb_busy       = (state_q == PKT);

endmodule

// File: tb/tb_egr_wadj_port_arb.sv
// tb/tb_egr_wadj_port_arb.sv - self-checking bench for egr_wadj_port_arb against a packet-order reference model
module tb_egr_wadj_port_arb;
  import ptp_bridge_pkg::*;

  localparam int NP = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic          first;
    logic [DW-1:0] data;
    logic [3:0]    keep;
    logic          last;
    logic          umd;
    SEGMENT_INFO_S seg;
  } beat_t;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NP-1:0]              igr_tvalid;
  logic [NP-1:0][DW-1:0]      igr_tdata;
  logic [NP-1:0][3:0]         igr_tkeep;
  logic [NP-1:0]              igr_tlast;
  logic [NP-1:0][0:0]         igr_tuser_usermetadata;
  SEGMENT_INFO_S [NP-1:0]     igr_tuser_segment_info;
  logic [NP-1:0]              igr_tready;
  logic                       egr_tvalid;
  logic [DW-1:0]              egr_tdata;
  logic [3:0]                 egr_tkeep;
  logic                       egr_tlast;
  logic [0:0]                 egr_tuser_usermetadata;
  SEGMENT_INFO_S              egr_tuser_segment_info;
  logic                       egr_tready;
  logic [1:0]                 egr_grant_port;
  logic                       arb_busy;

  egr_wadj_port_arb #(
    .NUM_PORTS          (NP),
    .TDATA_WIDTH        (DW),
    .USERMETADATA_WIDTH (1)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .igr_tvalid             (igr_tvalid),
    .igr_tdata              (igr_tdata),
    .igr_tkeep              (igr_tkeep),
    .igr_tlast              (igr_tlast),
    .igr_tuser_usermetadata (igr_tuser_usermetadata),
    .igr_tuser_segment_info (igr_tuser_segment_info),
    .igr_tready             (igr_tready),
    .egr_tvalid             (egr_tvalid),
    .egr_tdata              (egr_tdata),
    .egr_tkeep              (egr_tkeep),
    .egr_tlast              (egr_tlast),
    .egr_tuser_usermetadata (egr_tuser_usermetadata),
    .egr_tuser_segment_info (egr_tuser_segment_info),
    .egr_tready             (egr_tready),
    .egr_grant_port         (egr_grant_port),
    .arb_busy               (arb_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  beat_t       pq   [NP][$];
  beat_t       mq   [NP][$];
  int          mlen [NP][$];
  logic [63:0] exp_q[$];
  int          egr_cyc[$];
  int          acc  [NP];
  int          mptr = 0;
  int          cyc  = 0;
  int          pc   = 0;
  bit          hold_v = 0;
  logic [63:0] hold_d;
  int          pat  [4] = '{1, 0, 0, 1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pk(input logic [DW-1:0] d, input logic [3:0] k, input logic u,
                                     input logic l, input SEGMENT_INFO_S s);
    return 64'({d, k, u, l, s});
  endfunction

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.first = (i == 0);
      b.data  = $urandom;
      b.keep  = 4'($urandom);
      b.last  = (i == len - 1);
      b.umd   = 1'($urandom);
      b.seg   = SEGMENT_INFO_S'($urandom);
      pq[p].push_back(b);
      mq[p].push_back(b);
    end
    mlen[p].push_back(len);
  endtask

  // Packet-order model: every port with packets left is requesting at each arbitration.
  task automatic plan();
    int cnt [NP];
    int total, p, q, len;
    bit found;
    beat_t b;
    SEGMENT_INFO_S s;
    total = 0;
    for (int i = 0; i < NP; i++) begin
      cnt[i] = mlen[i].size();
      total += cnt[i];
    end
    while (total > 0) begin
      p = 0;
      found = 0;
`ifdef EGR_WADJ_ARB_PRIO_EN
      if (cnt[0] > 0) begin
        p = 0;
        found = 1;
      end else begin
        for (int i = 0; i < NP; i++) begin
          q = (mptr + i) % NP;
          if (!found && q != 0 && cnt[q] > 0) begin
            p = q;
            found = 1;
          end
        end
        mptr = (p + 1) % NP;
      end
`else
      for (int i = 0; i < NP; i++) begin
        q = (mptr + i) % NP;
        if (!found && cnt[q] > 0) begin
          p = q;
          found = 1;
        end
      end
      mptr = (p + 1) % NP;
`endif
      len = mlen[p].pop_front();
      for (int i = 0; i < len; i++) begin
        b = mq[p].pop_front();
        s = b.seg;
        s.igr_port = 4'(p);
        exp_q.push_back(pk(b.data, b.keep, b.umd, b.last, s));
      end
      cnt[p]--;
      total--;
    end
  endtask

  task automatic drive_idle();
    igr_tvalid = '0;
    igr_tdata = '0;
    igr_tkeep = '0;
    igr_tlast = '0;
    igr_tuser_usermetadata = '0;
    igr_tuser_segment_info = '0;
    egr_tready = 1'b0;
  endtask

  // One clock: drive, observe away from the edge, score handshakes, advance.
  task automatic step(input int mode, input bit gaps);
    beat_t b;
    logic [63:0] cur;
    for (int p = 0; p < NP; p++) begin
      if (pq[p].size() > 0) begin
        b = pq[p][0];
        igr_tvalid[p] = b.first || !gaps || ($urandom_range(0, 3) != 0);
        igr_tdata[p] = b.data;
        igr_tkeep[p] = b.keep;
        igr_tlast[p] = b.last;
        igr_tuser_usermetadata[p] = b.umd;
        igr_tuser_segment_info[p] = b.seg;
      end else begin
        igr_tvalid[p] = 1'b0;
        igr_tdata[p] = $urandom;
        igr_tkeep[p] = 4'($urandom);
        igr_tlast[p] = 1'($urandom);
        igr_tuser_usermetadata[p] = 1'($urandom);
        igr_tuser_segment_info[p] = SEGMENT_INFO_S'($urandom);
      end
    end
    case (mode)
      0:       egr_tready = 1'b1;
      1:       egr_tready = ($urandom_range(0, 2) != 0);
      default: egr_tready = pat[pc % 4][0];
    endcase
    #1;
    cur = pk(egr_tdata, egr_tkeep, egr_tuser_usermetadata[0], egr_tlast, egr_tuser_segment_info);
    chk("tready_onehot", 64'($onehot0(igr_tready)), 64'd1);
    if (hold_v) begin
      chk("hold_valid", 64'(egr_tvalid), 64'd1);
      chk("hold_data", cur, hold_d);
    end
    hold_v = egr_tvalid && !egr_tready;
    hold_d = cur;
    if (egr_tvalid && egr_tready) begin
      if (exp_q.size() == 0) begin
        chk("egr_unexpected", cur, 64'hx);
      end else begin
        chk("egr_beat", cur, exp_q.pop_front());
      end
      egr_cyc.push_back(cyc);
    end
    for (int p = 0; p < NP; p++) begin
      if (igr_tvalid[p] && igr_tready[p]) begin
        chk("grant_port", 64'(egr_grant_port), 64'(p));
        chk("arb_busy", 64'(arb_busy), 64'd1);
        void'(pq[p].pop_front());
        acc[p]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    pc++;
  endtask

  function automatic int pending();
    int n;
    n = exp_q.size();
    for (int p = 0; p < NP; p++) n += pq[p].size();
    return n;
  endfunction

  task automatic run(input int mode, input bit gaps);
    int n;
    plan();
    pc = 0;
    n = 0;
    while (pending() > 0 && n < 3000) begin
      step(mode, gaps);
      n++;
    end
    chk("drain_left", 64'(pending()), 64'd0);
  endtask

  initial begin
    int cstart, base, n;
    for (int p = 0; p < NP; p++) acc[p] = 0;
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tready", 64'(igr_tready), 64'd0);
    chk("rst_tvalid", 64'(egr_tvalid), 64'd0);
    chk("rst_tlast", 64'(egr_tlast), 64'd0);
    chk("rst_grant", 64'(egr_grant_port), 64'd0);
    chk("rst_busy", 64'(arb_busy), 64'd0);
    chk("rst_tdata", 64'(egr_tdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All four ports, single-beat packets, tready high: order 0,1,2,3,0 with one bubble each.
    egr_cyc.delete();
    cstart = cyc;
    for (int p = 0; p < NP; p++) add_pkt(p, 1);
    add_pkt(0, 1);
    run(0, 0);
    chk("egr_beats_p1", 64'(egr_cyc.size()), 64'd5);
    if (egr_cyc.size() > 0) chk("first_latency", 64'(egr_cyc[0] - cstart), 64'd2);
    for (int i = 1; i < egr_cyc.size(); i++)
      chk("bubble_spacing", 64'(egr_cyc[i] - egr_cyc[i-1]), 64'd2);

    // Move pointer to 2, then a 5-beat packet on port 2 while port 1 waits.
    add_pkt(1, 1);
    run(0, 0);
    add_pkt(2, 5);
    add_pkt(1, 3);
    run(0, 0);

    // 6-beat packet under tready pattern 1,0,0,1; leaves the pointer at 3.
    add_pkt(2, 6);
    run(2, 0);

    // Wrap: only port 0 valid, then ports 0 and 1 together expose the new pointer.
    add_pkt(0, 1);
    run(0, 0);
    add_pkt(0, 1);
    add_pkt(1, 1);
    run(0, 0);

    // Ports 0 and 1 continuously requesting.
    for (int i = 0; i < 4; i++) begin
      add_pkt(0, $urandom_range(1, 3));
      add_pkt(1, $urandom_range(1, 3));
    end
    run(1, 0);

    // Randomised traffic, valid gaps mid-packet, random backpressure.
    for (int it = 0; it < 10; it++) begin
      for (int p = 0; p < NP; p++) begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) add_pkt(p, $urandom_range(1, 6));
      end
      run(1, 1);
    end

    // Reset on the third beat of a 5-beat packet.
    base = acc[0];
    add_pkt(0, 5);
    plan();
    n = 0;
    while (acc[0] - base < 2 && n < 100) begin
      step(0, 0);
      n++;
    end
    chk("rst_mid_wait", 64'(acc[0] - base), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("rstm_tready", 64'(igr_tready), 64'd0);
    chk("rstm_tvalid", 64'(egr_tvalid), 64'd0);
    chk("rstm_tlast", 64'(egr_tlast), 64'd0);
    chk("rstm_grant", 64'(egr_grant_port), 64'd0);
    chk("rstm_busy", 64'(arb_busy), 64'd0);
    chk("rstm_tdata", 64'(egr_tdata), 64'd0);
    for (int p = 0; p < NP; p++) pq[p].delete();
    exp_q.delete();
    mptr = 0;
    hold_v = 0;
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < NP; p++) add_pkt(p, 1);
    run(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
